// File: rtl/vend_pkg.sv
// Shared definitions for the multi-product vending controller: state encoding,
// coin values and coin-decoding helpers.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    REFUND = 2'd3
  } state_t;

  localparam logic [2:0] COIN_05 = 3'd1;
  localparam logic [2:0] COIN_10 = 3'd2;
  localparam logic [2:0] COIN_20 = 3'd4;

  function automatic logic coin_onehot(input logic [2:0] coin);
    return (coin == COIN_05) || (coin == COIN_10) || (coin == COIN_20);
  endfunction

  // Value in 0.5 units; anything not one-hot is worth nothing
  function automatic logic [2:0] coin_value(input logic [2:0] coin);
    case (coin)
      COIN_05: return 3'd1;
      COIN_10: return 3'd2;
      COIN_20: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Idle counter for the accumulate phase; o_expire is high once TIMEOUT-1 idle
// cycles have been counted, so the next idle cycle is the timeout one.
module vend_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next;
  logic             r_expire;

  assign w_next   = (r_cnt == LAST) ? r_cnt : r_cnt + 1'b1;
  assign o_expire = r_expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_expire <= (TIMEOUT == 1);
    end else if (i_clr) begin
      r_cnt    <= '0;
      r_expire <= (TIMEOUT == 1);
    end else if (i_en) begin
      r_cnt    <= w_next;
      r_expire <= (w_next == LAST);
    end
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product coin vending controller: accumulates credit, dispenses with
// exact change, refunds on cancel or idle timeout, flags multi-hot coins.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int                          N_ITEMS  = 2,
  parameter int                          SEL_W    = 1,
  parameter int                          CREDIT_W = 5,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES   = {5'd5, 5'd3},
  parameter int                          TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          i_coin,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_cancel,
  output logic                o_vend,
  output logic [SEL_W-1:0]    o_vend_item,
  output logic [CREDIT_W-1:0] o_change,
  output logic                o_change_vld,
  output logic                o_coin_err,
  output logic                o_busy
);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [SEL_W-1:0]    r_sel;

  logic                w_valid;
  logic                w_multi;
  logic [CREDIT_W-1:0] w_val;
  logic [CREDIT_W-1:0] w_sum;
  logic [CREDIT_W-1:0] w_price_in;
  logic [CREDIT_W-1:0] w_price_q;
  logic                w_tmr_clr;
  logic                w_tmr_en;
  logic                w_expire;

  // Out-of-range selects fall back to item 0 rather than reading past PRICES
  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] s);
    if (int'(s) >= N_ITEMS) return PRICES[CREDIT_W-1:0];
    return PRICES[int'(s)*CREDIT_W +: CREDIT_W];
  endfunction

  assign w_valid    = coin_onehot(i_coin);
  assign w_multi    = (i_coin != 3'd0) && !w_valid;
  assign w_val      = CREDIT_W'(coin_value(i_coin));
  assign w_sum      = r_credit + w_val;
  assign w_price_in = price_of(i_sel);
  assign w_price_q  = price_of(r_sel);

  // Multi-hot coins neither clear nor advance the timer
  assign w_tmr_clr = (r_state != ACCUM) || w_valid;
  assign w_tmr_en  = (r_state == ACCUM) && (i_coin == 3'd0) && !i_cancel;

  vend_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_credit     <= '0;
      r_sel        <= '0;
      o_vend       <= 1'b0;
      o_vend_item  <= '0;
      o_change     <= '0;
      o_change_vld <= 1'b0;
      o_coin_err   <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_vend       <= 1'b0;
      o_vend_item  <= '0;
      o_change     <= '0;
      o_change_vld <= 1'b0;
      o_coin_err   <= w_multi;
      o_busy       <= 1'b0;
      // Strobes are launched on the edge that enters VEND/REFUND
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_credit <= w_val;
            r_sel    <= i_sel;
            if (w_val >= w_price_in) begin
              r_state      <= VEND;
              o_vend       <= 1'b1;
              o_vend_item  <= i_sel;
              o_change     <= w_val - w_price_in;
              o_change_vld <= 1'b1;
              o_busy       <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (i_cancel) begin
            r_state      <= REFUND;
            r_credit     <= w_valid ? w_sum : r_credit;
            o_change     <= w_valid ? w_sum : r_credit;
            o_change_vld <= 1'b1;
            o_busy       <= 1'b1;
          end else if (w_valid) begin
            r_credit <= w_sum;
            if (w_sum >= w_price_q) begin
              r_state      <= VEND;
              o_vend       <= 1'b1;
              o_vend_item  <= r_sel;
              o_change     <= w_sum - w_price_q;
              o_change_vld <= 1'b1;
              o_busy       <= 1'b1;
            end
          end else if ((i_coin == 3'd0) && w_expire) begin
            r_state      <= REFUND;
            o_change     <= r_credit;
            o_change_vld <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        VEND, REFUND: begin
          r_credit <= '0;
          r_state  <= IDLE;
        end
        default: begin
          r_credit <= '0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule
